// File: rtl/b05_disp_pkg.sv
// b05_disp_pkg: segment codes and FSM state encoding shared by the b05 display reader
package b05_disp_pkg;

    localparam logic [6:0] SEG_D0    = 7'b0111111;
    localparam logic [6:0] SEG_D1    = 7'b0011000;
    localparam logic [6:0] SEG_D2    = 7'b1101100;
    localparam logic [6:0] SEG_D3    = 7'b1111001;
    localparam logic [6:0] SEG_D4    = 7'b1011010;
    localparam logic [6:0] SEG_D5    = 7'b1110110;
    localparam logic [6:0] SEG_D6    = 7'b1110111;
    localparam logic [6:0] SEG_D7    = 7'b0011100;
    localparam logic [6:0] SEG_D8    = 7'b1111111;
    localparam logic [6:0] SEG_D9    = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_REPORT = 3'd1;
    localparam state_t ST_BLANK  = 3'd2;
    localparam state_t ST_DASH   = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

endpackage

// File: rtl/b05_disp_reader_if.sv
// b05_disp_reader_if: display buses in, decoded readout out; ERR_CNT exists only with B05_DISP_ERRCNT_EN
interface b05_disp_reader_if;

    logic       SIGN;
    logic [6:0] DISPMAX1;
    logic [6:0] DISPMAX2;
    logic [6:0] DISPMAX3;
    logic [6:0] DISPNUM1;
    logic [6:0] DISPNUM2;
    logic       VALID;
    logic [7:0] MAX_MAG;
    logic       MAX_NEG;
    logic [4:0] NUM_VAL;
    logic       BLANK;
    logic       DASH;
    logic       ERR;
`ifdef B05_DISP_ERRCNT_EN
    logic [7:0] ERR_CNT;
`endif

    modport master (
`ifdef B05_DISP_ERRCNT_EN
        input  ERR_CNT,
`endif
        output SIGN, DISPMAX1, DISPMAX2, DISPMAX3, DISPNUM1, DISPNUM2,
        input  VALID, MAX_MAG, MAX_NEG, NUM_VAL, BLANK, DASH, ERR
    );

    modport slave (
`ifdef B05_DISP_ERRCNT_EN
        output ERR_CNT,
`endif
        input  SIGN, DISPMAX1, DISPMAX2, DISPMAX3, DISPNUM1, DISPNUM2,
        output VALID, MAX_MAG, MAX_NEG, NUM_VAL, BLANK, DASH, ERR
    );

endinterface

// File: rtl/b05_seg_dec.sv
// b05_seg_dec: 7-segment code to decimal digit, flagging codes outside the digit table
module b05_seg_dec
    import b05_disp_pkg::*;
(
    input  logic [6:0] i_code,
    output logic [3:0] o_digit,
    output logic       o_illegal
);

    // table lookup; anything not in the table decodes as 0 with the illegal flag set
    always_comb begin
        o_illegal = 1'b0;
        case (i_code)
            SEG_D0:  o_digit = 4'd0;
            SEG_D1:  o_digit = 4'd1;
            SEG_D2:  o_digit = 4'd2;
            SEG_D3:  o_digit = 4'd3;
            SEG_D4:  o_digit = 4'd4;
            SEG_D5:  o_digit = 4'd5;
            SEG_D6:  o_digit = 4'd6;
            SEG_D7:  o_digit = 4'd7;
            SEG_D8:  o_digit = 4'd8;
            SEG_D9:  o_digit = 4'd9;
            default: begin
                o_digit   = 4'd0;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/b05_disp_reader.sv
// b05_disp_reader: debounces and decodes the b05 display buses; B05_DISP_ERRCNT_EN adds ERR_CNT
module b05_disp_reader
    import b05_disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input logic         CLOCK,
    input logic         RESET,
    b05_disp_reader_if.slave bus
);

    localparam logic [3:0]  SAT      = 4'(STABLE_CYCLES);
    localparam logic [35:0] DASH_PAT = {1'b1, {5{SEG_DASH}}};
    localparam logic [35:0] BLANK_PAT = {1'b0, {5{SEG_BLANK}}};

    logic [35:0] w_frame;
    logic [35:0] r_snap;
    logic [35:0] r_prev;
    logic [3:0]  r_cnt;
    logic        w_match;
    logic        w_fire;
    logic [6:0]  w_code [5];
    logic [3:0]  w_dig  [5];
    logic        w_ill  [5];
    logic        w_legal;
    state_t      r_state;
    state_t      w_class;
    state_t      w_next;
    logic        r_err;
    logic [7:0]  r_max_mag;
    logic        r_max_neg;
    logic [4:0]  r_num_val;
    logic        r_blank;
    logic        r_dash;

    assign w_frame = {bus.SIGN, bus.DISPMAX1, bus.DISPMAX2, bus.DISPMAX3, bus.DISPNUM1, bus.DISPNUM2};
    assign w_match = r_snap == r_prev;
    // classification happens exactly on the edge the counter saturates; a mismatch blocks it
    assign w_fire  = w_match && r_cnt == SAT - 4'd1;

    assign w_code[0] = r_snap[34:28];
    assign w_code[1] = r_snap[27:21];
    assign w_code[2] = r_snap[20:14];
    assign w_code[3] = r_snap[13:7];
    assign w_code[4] = r_snap[6:0];

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dec
            b05_seg_dec u_dec (
                .i_code    (w_code[g]),
                .o_digit   (w_dig[g]),
                .o_illegal (w_ill[g])
            );
        end
    endgenerate

    // leading digits of MAX and NUM may only be 0 or 1
    assign w_legal = !(w_ill[0] || w_ill[1] || w_ill[2] || w_ill[3] || w_ill[4])
                     && w_dig[0] <= 4'd1 && w_dig[3] <= 4'd1;

    // frame classification and next state
    always_comb begin
        w_class = r_snap == BLANK_PAT ? ST_BLANK :
                  r_snap == DASH_PAT  ? ST_DASH  :
                  w_legal             ? ST_REPORT : ST_HOLD;
        w_next  = w_fire                 ? w_class :
                  r_state == ST_IDLE     ? ST_IDLE :
                  r_state == ST_HOLD && r_cnt != SAT ? ST_IDLE : ST_HOLD;
    end

    // snapshot pipeline and saturating stability counter
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_snap <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_snap <= w_frame;
            r_prev <= r_snap;
            r_cnt  <= !w_match ? 4'd0 : r_cnt == SAT ? SAT : r_cnt + 4'd1;
        end
    end

    // FSM and output registers, loaded on the edge that enters the classified state
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b0;
            r_max_mag <= '0;
            r_max_neg <= 1'b0;
            r_num_val <= '0;
            r_blank   <= 1'b0;
            r_dash    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_fire && w_class == ST_HOLD;
            if (w_fire) begin
                r_blank <= w_class == ST_BLANK;
                r_dash  <= w_class == ST_DASH;
            end
            if (w_fire && w_class == ST_REPORT) begin
                r_max_mag <= 8'd100 * 8'(w_dig[0]) + 8'd10 * 8'(w_dig[1]) + 8'(w_dig[2]);
                r_max_neg <= r_snap[35];
                r_num_val <= 5'd10 * 5'(w_dig[3]) + 5'(w_dig[4]);
            end else if (w_fire && w_class == ST_DASH) begin
                r_max_mag <= '0;
                r_max_neg <= 1'b0;
                r_num_val <= '0;
            end
        end
    end

    assign bus.VALID   = r_state == ST_REPORT;
    assign bus.MAX_MAG = r_max_mag;
    assign bus.MAX_NEG = r_max_neg;
    assign bus.NUM_VAL = r_num_val;
    assign bus.BLANK   = r_blank;
    assign bus.DASH    = r_dash;
    assign bus.ERR     = r_err;

`ifdef B05_DISP_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // saturating count of ERR pulses, updated on the same edge that raises ERR
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            r_err_cnt <= '0;
        else if (w_fire && w_class == ST_HOLD && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign bus.ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_b05_disp_reader.sv
// tb_b05_disp_reader: random and directed frames checked against a frame-history reference model
module tb_b05_disp_reader;

    localparam int S = 2;
    localparam logic [6:0] SEG [10] = '{7'b0111111, 7'b0011000, 7'b1101100, 7'b1111001, 7'b1011010,
                                        7'b1110110, 7'b1110111, 7'b0011100, 7'b1111111, 7'b1111110};

    logic CLOCK = 1'b0;
    logic RESET;

    b05_disp_reader_if bus ();

    b05_disp_reader #(.STABLE_CYCLES(S)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid, n_err, v_at, t_idx;

    logic [35:0] hq [$];
    logic        e_valid, e_err, e_neg, e_blank, e_dash;
    logic [7:0]  e_mag, e_errcnt;
    logic [4:0]  e_num;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mk(input bit s, input int d1, input int d2, input int d3,
                                       input int n1, input int n2);
        return {s, SEG[d1], SEG[d2], SEG[d3], SEG[n1], SEG[n2]};
    endfunction

    function automatic int dec(input logic [6:0] c);
        for (int i = 0; i < 10; i++)
            if (SEG[i] == c) return i;
        return -1;
    endfunction

    task automatic drive(input logic [35:0] f);
        {bus.SIGN, bus.DISPMAX1, bus.DISPMAX2, bus.DISPMAX3, bus.DISPNUM1, bus.DISPNUM2} = f;
    endtask

    task automatic model_reset();
        hq.delete();
        hq.push_back(36'd0);
        hq.push_back(36'd0);
        {e_valid, e_err, e_neg, e_blank, e_dash} = '0;
        e_mag = '0;
        e_num = '0;
        e_errcnt = '0;
    endtask

    // a frame is reported on the edge where it has been sampled S+1 times in a row, and only
    // on the first such edge of that run; hq holds the samples taken so far
    task automatic model_edge(input logic [35:0] f_in);
        logic        fire;
        logic [35:0] f;
        logic [35:0] dash_pat;
        int          n, d [5];
        bit          legal;
        n = hq.size();
        f = hq[n-1];
        dash_pat = {1'b1, {5{7'b1000000}}};
        e_valid = 1'b0;
        e_err = 1'b0;
        fire = n >= S + 1;
        for (int i = 1; i <= S; i++)
            if (n - 1 - i >= 0 && hq[n-1-i] != f) fire = 1'b0;
        if (n >= S + 2 && hq[n-S-2] == f) fire = 1'b0;
        if (fire) begin
            d[0] = dec(f[34:28]);
            d[1] = dec(f[27:21]);
            d[2] = dec(f[20:14]);
            d[3] = dec(f[13:7]);
            d[4] = dec(f[6:0]);
            legal = d[0] inside {0, 1} && d[3] inside {0, 1} && d[1] >= 0 && d[2] >= 0 && d[4] >= 0;
            if (f == 36'd0) begin
                e_blank = 1'b1;
                e_dash = 1'b0;
            end else if (f == dash_pat) begin
                e_blank = 1'b0;
                e_dash = 1'b1;
                e_mag = '0;
                e_neg = 1'b0;
                e_num = '0;
            end else if (legal) begin
                e_valid = 1'b1;
                e_blank = 1'b0;
                e_dash = 1'b0;
                e_mag = 8'(100 * d[0] + 10 * d[1] + d[2]);
                e_neg = f[35];
                e_num = 5'(10 * d[3] + d[4]);
            end else begin
                e_err = 1'b1;
                e_blank = 1'b0;
                e_dash = 1'b0;
                if (e_errcnt != 8'hFF) e_errcnt++;
            end
        end
        hq.push_back(f_in);
        while (hq.size() > S + 2) void'(hq.pop_front());
    endtask

    task automatic check_outs();
        chk("VALID", 32'(bus.VALID), 32'(e_valid));
        chk("ERR", 32'(bus.ERR), 32'(e_err));
        chk("MAX_MAG", 32'(bus.MAX_MAG), 32'(e_mag));
        chk("MAX_NEG", 32'(bus.MAX_NEG), 32'(e_neg));
        chk("NUM_VAL", 32'(bus.NUM_VAL), 32'(e_num));
        chk("BLANK", 32'(bus.BLANK), 32'(e_blank));
        chk("DASH", 32'(bus.DASH), 32'(e_dash));
`ifdef B05_DISP_ERRCNT_EN
        chk("ERR_CNT", 32'(bus.ERR_CNT), 32'(e_errcnt));
`endif
    endtask

    task automatic tick(input logic [35:0] f);
        drive(f);
        @(posedge CLOCK);
        model_edge(f);
        @(negedge CLOCK);
        check_outs();
        if (bus.VALID) begin
            n_valid++;
            v_at = t_idx;
        end
        if (bus.ERR) n_err++;
        t_idx++;
    endtask

    task automatic hold(input logic [35:0] f, input int n);
        repeat (n) tick(f);
    endtask

    task automatic phase();
        n_valid = 0;
        n_err = 0;
        t_idx = 0;
        v_at = -1;
    endtask

    task automatic mid_reset();
        #2 RESET = 1'b1;
        #1 model_reset();
        check_outs();
        chk("rst_valid_now", 32'(bus.VALID), 32'd0);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1 check_outs();
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    logic [35:0] f1, f2, fa, fb, fe, fr;
    logic [6:0]  c [5];

    initial begin
        f1 = mk(0, 1, 8, 6, 1, 3);
        f2 = mk(1, 0, 4, 2, 0, 7);
        fa = mk(0, 1, 1, 6, 1, 3);
        fb = mk(0, 1, 2, 6, 1, 3);
        fe = mk(0, 2, 8, 6, 1, 3);
        RESET = 1'b1;
        drive(36'd0);
        model_reset();
        @(negedge CLOCK);
        @(negedge CLOCK);
        check_outs();
        RESET = 1'b0;

        phase();
        hold(f1, 5);
        chk("t1_nvalid", 32'(n_valid), 32'd1);
        chk("t1_valid_edge", 32'(v_at), 32'd3);
        chk("t1_mag", 32'(bus.MAX_MAG), 32'd186);
        chk("t1_num", 32'(bus.NUM_VAL), 32'd13);

        phase();
        hold(36'd0, 5);
        chk("blank_lvl", 32'(bus.BLANK), 32'd1);
        chk("blank_keep_mag", 32'(bus.MAX_MAG), 32'd186);
        chk("blank_nvalid", 32'(n_valid), 32'd0);

        phase();
        hold({1'b1, {5{7'b1000000}}}, 5);
        chk("dash_lvl", 32'(bus.DASH), 32'd1);
        chk("dash_mag", 32'(bus.MAX_MAG), 32'd0);
        chk("dash_nvalid", 32'(n_valid), 32'd0);

        phase();
        for (int i = 0; i < 6; i++) tick(i[0] ? fb : fa);
        chk("toggle_nvalid", 32'(n_valid), 32'd0);
        hold(fb, 6);
        chk("settle_nvalid", 32'(n_valid), 32'd1);
        chk("settle_mag", 32'(bus.MAX_MAG), 32'd126);

        phase();
        hold(fe, 6);
        chk("lead_err_n", 32'(n_err), 32'd1);
        chk("lead_err_nvalid", 32'(n_valid), 32'd0);
`ifdef B05_DISP_ERRCNT_EN
        chk("lead_err_cnt", 32'(bus.ERR_CNT), 32'd1);
`endif

        phase();
        hold(f2, 3);
        chk("pre_rst_nvalid", 32'(n_valid), 32'd0);
        mid_reset();
        chk("rst_mag", 32'(bus.MAX_MAG), 32'd0);
        hold(f2, 5);
        chk("post_rst_nvalid", 32'(n_valid), 32'd1);
        chk("post_rst_neg", 32'(bus.MAX_NEG), 32'd1);
        chk("post_rst_mag", 32'(bus.MAX_MAG), 32'd42);

        for (int it = 0; it < 300; it++) begin
            int k;
            k = $urandom_range(0, 9);
            fr = mk(1'($urandom), $urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 1), $urandom_range(0, 9));
            if (k == 0) fr = {1'b1, {5{7'b1000000}}};
            else if (k == 1) fr = 36'd0;
            else if (k == 2) begin
                {c[0], c[1], c[2], c[3], c[4]} = fr[34:0];
                c[$urandom_range(0, 4)] = 7'($urandom);
                fr = {fr[35], c[0], c[1], c[2], c[3], c[4]};
            end
            hold(fr, $urandom_range(1, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/b05_disp_reader.md
Name: b05_disp_reader

Overview:
- Observer/decoder at the far end of the b05 display interface.
- Samples the five 7-segment buses plus SIGN and decodes them back to binary: a signed maximum value (hundreds, tens, units) and a peak count (tens, units).
- Reports each new stable frame once, through a one-cycle VALID pulse.
- Used as a scoreboard/monitor beside b05 and as front-end logic for a host readout.

Parameters:
- STABLE_CYCLES, 2: number of consecutive identical sampled frames required before a frame is decoded (legal range 1..15).

Ports:
- CLOCK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SIGN  in  1  sign/dash indicator from the display driver.
- DISPMAX1  in  7  hundreds digit of MAX (segment code).
- DISPMAX2  in  7  tens digit of MAX.
- DISPMAX3  in  7  units digit of MAX.
- DISPNUM1  in  7  tens digit of NUM.
- DISPNUM2  in  7  units digit of NUM.
- VALID  out  1  one-cycle pulse when a new decoded frame is presented.
- MAX_MAG  out  8  decoded magnitude of MAX, 0..199.
- MAX_NEG  out  1  decoded sign of MAX (copy of SIGN for the frame).
- NUM_VAL  out  5  decoded count, 0..19.
- BLANK  out  1  level: the current stable frame is all-zero (display disabled).
- DASH  out  1  level: the current stable frame is the reset pattern (all buses 1000000).
- ERR  out  1  one-cycle pulse: a stable frame contained an illegal digit code.

Behaviour:
- Reset values: VALID=0, MAX_MAG=0, MAX_NEG=0, NUM_VAL=0, BLANK=0, DASH=0, ERR=0. Internal state: FSM in ST_IDLE, stability counter 0, snapshot registers 0.
- Reset is asynchronous. Asserting it mid-settle or mid-report clears everything at once; no pulse is emitted afterwards.
- Frame = {SIGN, DISPMAX1..3, DISPNUM1..2}, 36 bits.
- Sampling: the frame is registered into SNAP every cycle. SNAP is compared with PREV, the previous SNAP.
  - Any mismatch reloads the counter to 0.
  - A match increments it, saturating at STABLE_CYCLES.
- Latency: a frame applied at input before edge k and held produces its outputs after edge k+STABLE_CYCLES+1.
- Digit code table:
  - 0=0111111, 1=0011000, 2=1101100, 3=1111001, 4=1011010
  - 5=1110110, 6=1110111, 7=0011100, 8=1111111, 9=1111110
  - Any other code is illegal.
- DISPMAX1 and DISPNUM1 accept only digit 0 or 1; any other legal digit in these positions is also illegal.
- Arithmetic:
  - MAX_MAG = 100*d1 + 10*d2 + d3, computed in 8 bits with no overflow possible.
  - NUM_VAL = 10*n1 + n2.
- FSM states:
  - ST_IDLE: wait for the counter to reach STABLE_CYCLES, then classify the frame.
    - All-zero → ST_BLANK.
    - Every bus 1000000 and SIGN=1 → ST_DASH.
    - All digits legal → ST_REPORT.
    - Otherwise pulse ERR and go to ST_HOLD.
  - ST_REPORT: load MAX_MAG/MAX_NEG/NUM_VAL, pulse VALID for one cycle, clear BLANK/DASH, go to ST_HOLD.
  - ST_BLANK: set BLANK=1, keep the value outputs, go to ST_HOLD.
  - ST_DASH: set DASH=1, clear the value outputs to 0, go to ST_HOLD.
  - ST_HOLD: stay while the counter is saturated. Any mismatch returns to ST_IDLE. BLANK/DASH persist until the next classification.
- Each distinct stable frame is reported exactly once. A frame identical to the last reported one, reached again after a glitch, is reported again.
- SIGN=1 with digits 000 is legal: MAX_MAG=0, MAX_NEG=1.
- Simultaneous events: a mismatch arriving in the same cycle the counter saturates wins; nothing is classified that cycle.

Optional Feature:
- Macro: B05_DISP_ERRCNT_EN.
- Defined: adds output ERR_CNT[7:0]. It increments on every ERR pulse, saturates at 255, and is cleared by RESET.
- Undefined: no port and no counter; ERR behaviour is unchanged.

Decomposition:
- Shared package b05_disp_pkg holds:
  - the ten segment-code constants SEG_D0..SEG_D9;
  - SEG_BLANK and SEG_DASH;
  - the FSM state typedef (ST_IDLE, ST_REPORT, ST_BLANK, ST_DASH, ST_HOLD).
- Sub-module b05_seg_dec: combinational, 7-bit code in → 4-bit digit plus illegal flag. Five instances: the two leading-digit instances have their legality additionally restricted to 0/1 in the parent.

Test Plan:
- Reset then frame SIGN=0, digits 1,8,6 / 1,3, held 5 cycles → one VALID, MAX_MAG=186, MAX_NEG=0, NUM_VAL=13, at edge 3 after application.
- All buses 1000000 with SIGN=1 → DASH=1, no VALID, MAX_MAG=0.
- All buses 0000000 with SIGN=0 → BLANK=1, previous values retained, no VALID.
- DISPMAX2 toggles 0011000/1101100 every cycle for 6 cycles, then settles to 1101100 → exactly one VALID after settling; nothing during the toggling.
- DISPMAX1=1101100 (digit 2), held → ERR pulse, no VALID; with B05_DISP_ERRCNT_EN, ERR_CNT=1.
- RESET asserted one cycle before the expected VALID → no pulse, all outputs 0 immediately, FSM in ST_IDLE.
